fp_normalize_round: RTL and testbench

Post-add normalization and rounding stage of the single-precision FP adder, the counterpart of the exponent-alignment stage. It accepts the raw significand sum, the common exponent, the sign and the guard/round/sticky bits produced during alignment. It normalizes the sum iteratively, one bit per cycle, then rounds to nearest-even and packs an IEEE-754 binary32 result. A valid/ready handshake is used on both sides.

---
 rtl/fp_normalize_round.sv | 154 +++++++++++++++
 tb/tb_fp_normalize_round.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fp_normalize_round.sv
// Post-add normalize / round-to-nearest-even / pack stage of the binary32 adder.
// Define FPNORM_DENORM_EN to encode tiny results as subnormals instead of flushing to zero.
module fp_normalize_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inValid,
  output logic        inReady,
  input  logic [24:0] sumMantissa,
  input  logic [7:0]  exponentIn,
  input  logic        signIn,
  input  logic        guardBit,
  input  logic        roundBit,
  input  logic        stickyBit,
  input  logic        bypassALU,
  input  logic [31:0] bypassResult,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends combinationally on ready on either side.
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state, state_nx;
  logic [24:0] mant;
  logic [8:0]  exp;
  logic        sign, g, r, s;
  logic        out_valid;

  logic        zero_in;
  logic        round_up;
  logic [24:0] mant_sum;
  logic [24:0] mant_rnd;
  logic [8:0]  exp_rnd;
  logic        grs_any;

  assign zero_in   = (sumMantissa == 25'd0) && !guardBit && !roundBit && !stickyBit;
  assign round_up  = g & (r | s | mant[0]);
  assign mant_sum  = mant + {24'd0, round_up};
  assign mant_rnd  = mant_sum[24] ? {1'b0, mant_sum[24:1]} : mant_sum;
  assign exp_rnd   = exp + {8'd0, mant_sum[24]};
  assign grs_any   = g | r | s;

  assign inReady   = (state == IDLE);
  assign outValid  = out_valid;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (inValid) state_nx = (bypassALU || zero_in) ? DONE : NORM;
      NORM: begin
        if (mant[24])                   state_nx = ROUND;
        else if (!mant[23] && exp > 9'd1) state_nx = NORM;
        else                            state_nx = ROUND;
      end
      ROUND: state_nx = DONE;
      DONE:  if (out_valid && outReady) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outValid rises one cycle after entering DONE, giving the accept-to-valid
  // latency of k+1 (bypass/zero) and k+3+n (arithmetic path).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant      <= '0;
      exp       <= '0;
      sign      <= 1'b0;
      g         <= 1'b0;
      r         <= 1'b0;
      s         <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (inValid) begin
          mant      <= sumMantissa;
          exp       <= {1'b0, exponentIn};
          sign      <= signIn;
          g         <= guardBit;
          r         <= roundBit;
          s         <= stickyBit;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          inexact   <= 1'b0;
          if (bypassALU)    result <= bypassResult;
          else if (zero_in) result <= 32'h0000_0000;
        end
        NORM: begin
          if (mant[24]) begin
            mant <= {1'b0, mant[24:1]};
            g    <= mant[0];
            r    <= g;
            s    <= r | s;
            exp  <= exp + 9'd1;
          end else if (!mant[23] && exp > 9'd1) begin
            mant <= {mant[23:0], g};
            g    <= r;
            r    <= 1'b0;
            exp  <= exp - 9'd1;
          end
        end
        ROUND: begin
          mant <= mant_rnd;
          exp  <= exp_rnd;
          if (exp_rnd >= 9'd255) begin
            result    <= {sign, 8'hFF, 23'h0};
            overflow  <= 1'b1;
            underflow <= 1'b0;
            inexact   <= 1'b1;
          end else if (!mant_rnd[23]) begin
`ifdef FPNORM_DENORM_EN
            result    <= {sign, 8'h00, mant_rnd[22:0]};
            overflow  <= 1'b0;
            underflow <= grs_any;
            inexact   <= grs_any;
`else
            result    <= {sign, 31'h0};
            overflow  <= 1'b0;
            underflow <= 1'b1;
            inexact   <= (mant != 25'd0) | grs_any;
`endif
          end else begin
            // Covers a subnormal that rounded up into the hidden bit: exp is 1 there.
            result    <= {sign, exp_rnd[7:0], mant_rnd[22:0]};
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= grs_any;
          end
        end
        DONE: begin
          if (!out_valid)    out_valid <= 1'b1;
          else if (outReady) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round: hand-computed binary32 results, latency,
// handshake, backpressure and mid-operation reset.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [24:0] sumMantissa;
  logic [7:0]  exponentIn;
  logic        signIn, guardBit, roundBit, stickyBit;
  logic        bypassALU;
  logic [31:0] bypassResult;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        overflow, underflow, inexact;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  fp_normalize_round dut (
    .clk(clk), .rst_n(rst_n),
    .inValid(inValid), .inReady(inReady),
    .sumMantissa(sumMantissa), .exponentIn(exponentIn), .signIn(signIn),
    .guardBit(guardBit), .roundBit(roundBit), .stickyBit(stickyBit),
    .bypassALU(bypassALU), .bypassResult(bypassResult),
    .outValid(outValid), .outReady(outReady),
    .result(result), .overflow(overflow), .underflow(underflow), .inexact(inexact),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Apply one operand, measure latency, check the packed result and flags,
  // optionally stall the output for `hold` cycles, then complete the transfer.
  task automatic do_op(input string tag,
                       input logic [24:0] m, input logic [7:0] e, input logic sg,
                       input logic gb, input logic rb, input logic sb,
                       input logic byp, input logic [31:0] bres,
                       input logic [31:0] exp_res, input logic exp_ov,
                       input logic exp_uf, input logic exp_ix,
                       input int exp_lat, input int hold);
    int lat;
    check({tag, "_in_ready"}, {31'd0, inReady}, 32'd1);
    sumMantissa = m; exponentIn = e; signIn = sg;
    guardBit = gb; roundBit = rb; stickyBit = sb;
    bypassALU = byp; bypassResult = bres;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0; bypassALU = 1'b0;
    lat = 0;
    while (!outValid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_out_valid"}, {31'd0, outValid}, 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    @(negedge clk);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_flags"}, {29'd0, overflow, underflow, inexact},
          {29'd0, exp_ov, exp_uf, exp_ix});
    check({tag, "_busy"}, {31'd0, inReady}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_result"}, result, exp_res);
      check({tag, "_hold_state"}, {30'd0, outValid, inReady}, 32'b10);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    check({tag, "_after_xfer"}, {30'd0, outValid, inReady}, 32'b01);
  endtask

  initial begin
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0;
    sumMantissa = '0; exponentIn = '0; signIn = 1'b0;
    guardBit = 1'b0; roundBit = 1'b0; stickyBit = 1'b0;
    bypassALU = 1'b0; bypassResult = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hs", {29'd0, outValid, inReady, dbg_state == 2'd0}, 32'b011);
    check("reset_result", result, 32'h0);
    check("reset_flags", {29'd0, overflow, underflow, inexact}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("carry",      25'h1000000, 8'd127, 0, 0, 0, 0, 0, 32'h0, 32'h40000000, 0, 0, 0, 3, 0);
    do_op("cancel",     25'h0400000, 8'd127, 0, 0, 0, 0, 0, 32'h0, 32'h3F000000, 0, 0, 0, 4, 0);
    do_op("rne_up",     25'h0800001, 8'd127, 0, 1, 0, 0, 0, 32'h0, 32'h3F800002, 0, 0, 1, 3, 0);
    do_op("rne_tie",    25'h0800000, 8'd127, 0, 1, 0, 0, 0, 32'h0, 32'h3F800000, 0, 0, 1, 3, 0);
    do_op("sticky",     25'h0800000, 8'd127, 0, 0, 0, 1, 0, 32'h0, 32'h3F800000, 0, 0, 1, 3, 0);
    do_op("rnd_carry",  25'h0FFFFFF, 8'd127, 1, 1, 1, 0, 0, 32'h0, 32'hC0000000, 0, 0, 1, 3, 0);
    do_op("rshift_grs", 25'h1000001, 8'd127, 0, 1, 0, 0, 0, 32'h0, 32'h40000001, 0, 0, 1, 3, 0);
    do_op("lshift_g",   25'h0400000, 8'd127, 0, 1, 0, 0, 0, 32'h0, 32'h3F000001, 0, 0, 0, 4, 0);
    do_op("deep_shift", 25'h0000001, 8'd127, 0, 0, 0, 0, 0, 32'h0, 32'h34000000, 0, 0, 0, 26, 0);
    do_op("overflow",   25'h1000000, 8'd254, 0, 0, 0, 0, 0, 32'h0, 32'h7F800000, 1, 0, 1, 3, 0);
    do_op("bypass",     25'h0000000, 8'd0,   0, 0, 0, 0, 1, 32'h7FC00000, 32'h7FC00000, 0, 0, 0, 1, 5);
    do_op("zero_sum",   25'h0000000, 8'd127, 1, 0, 0, 0, 0, 32'h0, 32'h00000000, 0, 0, 0, 1, 0);
`ifdef FPNORM_DENORM_EN
    do_op("tiny",       25'h0400000, 8'd1,   0, 0, 0, 0, 0, 32'h0, 32'h00400000, 0, 0, 0, 3, 0);
    do_op("shift_floor",25'h0000001, 8'd10,  0, 0, 0, 0, 0, 32'h0, 32'h00000200, 0, 0, 0, 12, 0);
`else
    do_op("tiny",       25'h0400000, 8'd1,   0, 0, 0, 0, 0, 32'h0, 32'h00000000, 0, 1, 1, 3, 0);
    do_op("shift_floor",25'h0000001, 8'd10,  1, 0, 0, 0, 0, 32'h0, 32'h80000000, 0, 1, 1, 12, 0);
`endif

    // Abort a long normalization with an asynchronous reset.
    sumMantissa = 25'h0000001; exponentIn = 8'd127; signIn = 1'b0;
    guardBit = 1'b0; roundBit = 1'b0; stickyBit = 1'b0;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_norm_state", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_hs", {29'd0, outValid, inReady, dbg_state == 2'd0}, 32'b011);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_valid", {30'd0, outValid, inReady}, 32'b01);
    do_op("post_reset", 25'h1000000, 8'd127, 0, 0, 0, 0, 0, 32'h0, 32'h40000000, 0, 0, 0, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
